// File: rtl/vram_fill_arb_pkg.sv
// Shared video constants, fill FSM state encoding and the constant-multiply
// helper used to turn a row number into a VRAM row base address.
package vram_fill_arb_pkg;

    localparam int VID_H_RES = 640;
    localparam int VID_V_RES = 480;
    localparam int VRAM_AW   = 19;
    localparam int PIX_W     = 12;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        FINISH
    } fill_state_e;

    // y * k for a constant k, unrolled into shifted adds so no multiplier is inferred
    function automatic logic [VRAM_AW-1:0] mulByConst(input logic [8:0] y, input int k);
        logic [VRAM_AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < VRAM_AW; i++) begin
            if (k[i]) begin
                acc = acc + (VRAM_AW'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/vram_fill_arb.sv
// VRAM port A arbiter: the CPU bus owns the port whenever it requests it,
// and a rectangle-fill engine uses the idle cycles to paint clipped rectangles.
module vram_fill_arb
    import vram_fill_arb_pkg::*;
#(
    parameter int H_RES = VID_H_RES,
    parameter int V_RES = VID_V_RES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [PIX_W-1:0]   cpu_wdata,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [9:0]         cfg_x0,
    input  logic [9:0]         cfg_w,
    input  logic [8:0]         cfg_y0,
    input  logic [8:0]         cfg_h,
    input  logic [PIX_W-1:0]   cfg_color,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [PIX_W-1:0]   vram_din,
    output logic               busy,
    output logic               done
);

    localparam logic [10:0]        HRES_WIDE = 11'(H_RES);
    localparam logic [9:0]         HRES_NARROW = 10'(H_RES);
    localparam logic [9:0]         VRES_WIDE = 10'(V_RES);
    localparam logic [8:0]         VRES_NARROW = 9'(V_RES);
    localparam logic [VRAM_AW-1:0] ROW_STEP = VRAM_AW'(H_RES);

    fill_state_e        state_q, state_d;
    logic [9:0]         x0_q, x0_d;
    logic [9:0]         w_q, w_d;
    logic [9:0]         col_q, col_d;
    logic [8:0]         y0_q, y0_d;
    logic [8:0]         h_q, h_d;
    logic [8:0]         row_q, row_d;
    logic [VRAM_AW-1:0] rowBase_q, rowBase_d;
    logic [PIX_W-1:0]   color_q, color_d;

    logic               fillWe;
    logic [VRAM_AW-1:0] fillAddr;
    logic [9:0]         availW, clipW;
    logic [8:0]         availH, clipH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            w_q       <= '0;
            col_q     <= '0;
            y0_q      <= '0;
            h_q       <= '0;
            row_q     <= '0;
            rowBase_q <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            w_q       <= w_d;
            col_q     <= col_d;
            y0_q      <= y0_d;
            h_q       <= h_d;
            row_q     <= row_d;
            rowBase_q <= rowBase_d;
            color_q   <= color_d;
        end
    end

    // w_q/h_q hold the raw request until SETUP, then the clipped size during RUN
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        w_d       = w_q;
        col_d     = col_q;
        y0_d      = y0_q;
        h_d       = h_q;
        row_d     = row_q;
        rowBase_d = rowBase_q;
        color_d   = color_q;
        fillWe    = 1'b0;
        availW    = '0;
        availH    = '0;
        clipW     = '0;
        clipH     = '0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    x0_d    = cfg_x0;
                    w_d     = cfg_w;
                    y0_d    = cfg_y0;
                    h_d     = cfg_h;
                    color_d = cfg_color;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if ({1'b0, x0_q} < HRES_WIDE && {1'b0, y0_q} < VRES_WIDE) begin
                    availW = HRES_NARROW - x0_q;
                    availH = VRES_NARROW - y0_q;
                    clipW  = (w_q < availW) ? w_q : availW;
                    clipH  = (h_q < availH) ? h_q : availH;
                end
                w_d       = clipW;
                h_d       = clipH;
                col_d     = '0;
                row_d     = '0;
                rowBase_d = mulByConst(y0_q, H_RES) + VRAM_AW'(x0_q);
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (clipW == '0 || clipH == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (!cpu_req && !rst) begin
                    fillWe = 1'b1;
                    if (col_q == w_q - 10'd1) begin
                        col_d     = '0;
                        row_d     = row_q + 9'd1;
                        rowBase_d = rowBase_q + ROW_STEP;
                        if (row_q == h_q - 9'd1) begin
                            state_d = FINISH;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The bus always wins the port; when nobody writes, the address still follows the bus for reads
    always_comb begin
        fillAddr  = rowBase_q + VRAM_AW'(col_q);
        vram_we   = cpu_req ? cpu_we : fillWe;
        vram_addr = fillWe ? fillAddr : cpu_addr;
        vram_din  = fillWe ? color_q : cpu_wdata;
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
    end

endmodule

// File: tb/tb_vram_fill_arb.sv
// Self-checking bench for vram_fill_arb: directed corner cases plus randomized
// fills and bus traffic against a pixel-list model of the rectangle fill.
module tb_vram_fill_arb;
    import vram_fill_arb_pkg::*;

    localparam int H = 640;
    localparam int V = 480;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_req, cpu_we;
    logic [VRAM_AW-1:0] cpu_addr;
    logic [PIX_W-1:0]   cpu_wdata;
    logic               cfg_start, cfg_abort;
    logic [9:0]         cfg_x0, cfg_w;
    logic [8:0]         cfg_y0, cfg_h;
    logic [PIX_W-1:0]   cfg_color;
    logic               vram_we;
    logic [VRAM_AW-1:0] vram_addr;
    logic [PIX_W-1:0]   vram_din;
    logic               busy, done;

    int assertCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    vram_fill_arb #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_x0(cfg_x0), .cfg_w(cfg_w), .cfg_y0(cfg_y0), .cfg_h(cfg_h), .cfg_color(cfg_color),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
        .busy(busy), .done(done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [VRAM_AW-1:0] addr,
                                 input logic [PIX_W-1:0] data, input logic start, input logic abort,
                                 input logic reset);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        cfg_start = start;
        cfg_abort = abort;
        rst       = reset;
    endtask

    task automatic checkIdle(input string name);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'(($urandom) & 1), VRAM_AW'($urandom_range(0, H*V-1)), PIX_W'($urandom),
                      1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({name, ".idleBusy"}, 32'(busy), 32'd0);
        checkOutput({name, ".idleDone"}, 32'(done), 32'd0);
        checkOutput({name, ".idleWe"}, 32'(vram_we), 32'd0);
        checkOutput({name, ".idleAddr"}, 32'(vram_addr), 32'(cpu_addr));
    endtask

    // busMode: 0 quiet bus, 1 bus writes 0x00F to address 0 in RUN cycles 2-3, 2 random bus
    // abortAt: pixels written before abort (-1 none, -2 abort during SETUP); rstAt likewise for reset
    task automatic runFill(input string name, input int x0, input int y0, input int w, input int h,
                           input logic [PIX_W-1:0] color, input int busMode, input int abortAt,
                           input int rstAt, input bit spam);
        int unsigned expAddr[$];
        int cw, ch, n, pix, finishK, k;
        bit over, inSetup, inRun, abortNow, rstNow, fillNow, req;

        if (x0 >= H || y0 >= V) begin
            cw = 0;
            ch = 0;
        end else begin
            cw = (w < H - x0) ? w : H - x0;
            ch = (h < V - y0) ? h : V - y0;
        end
        for (int r = 0; r < ch; r++) begin
            for (int c = 0; c < cw; c++) begin
                expAddr.push_back(32'((y0 + r) * H + x0 + c));
            end
        end
        n = cw * ch;
        pix = 0;
        finishK = (n == 0) ? 2 : -1;
        over = 1'b0;

        @(posedge clk);
        #1;
        cfg_x0    = 10'(x0);
        cfg_y0    = 9'(y0);
        cfg_w     = 10'(w);
        cfg_h     = 9'(h);
        cfg_color = color;
        applyStimulus(1'b0, 1'b0, VRAM_AW'($urandom_range(0, H*V-1)), PIX_W'($urandom), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({name, ".startBusy"}, 32'(busy), 32'd0);
        checkOutput({name, ".startWe"}, 32'(vram_we), 32'd0);

        k = 0;
        while (!over) begin
            k++;
            @(posedge clk);
            #1;
            inSetup  = (k == 1);
            inRun    = (k >= 2) && (pix < n);
            case (busMode)
                1:       req = (k == 3 || k == 4);
                2:       req = ($urandom_range(0, 2) == 0);
                default: req = 1'b0;
            endcase
            abortNow = (abortAt == -2 && inSetup) || (abortAt >= 0 && inRun && pix == abortAt);
            rstNow   = (rstAt >= 0 && inRun && pix == rstAt);
            if (spam) begin
                cfg_x0    = 10'($urandom);
                cfg_y0    = 9'($urandom);
                cfg_w     = 10'($urandom);
                cfg_h     = 9'($urandom);
                cfg_color = PIX_W'($urandom);
            end
            if (busMode == 1) begin
                applyStimulus(req, 1'b1, '0, 12'h00F, spam && ($urandom_range(0, 1) == 0),
                              abortNow, rstNow);
            end else begin
                applyStimulus(req, 1'(($urandom) & 1), VRAM_AW'($urandom_range(0, H*V-1)),
                              PIX_W'($urandom), spam && ($urandom_range(0, 1) == 0), abortNow, rstNow);
            end
            fillNow = inRun && !req && !abortNow && !rstNow;

            @(negedge clk);
            if (req) begin
                checkOutput({name, ".busWe"}, 32'(vram_we), 32'(cpu_we));
                checkOutput({name, ".busAddr"}, 32'(vram_addr), 32'(cpu_addr));
                checkOutput({name, ".busData"}, 32'(vram_din), 32'(cpu_wdata));
            end else if (fillNow) begin
                checkOutput({name, ".fillWe"}, 32'(vram_we), 32'd1);
                checkOutput({name, ".fillAddr"}, 32'(vram_addr), expAddr[pix]);
                checkOutput({name, ".fillData"}, 32'(vram_din), 32'(color));
            end else begin
                checkOutput({name, ".quietWe"}, 32'(vram_we), 32'd0);
                checkOutput({name, ".quietAddr"}, 32'(vram_addr), 32'(cpu_addr));
            end
            if (!rstNow) begin
                checkOutput({name, ".busy"}, 32'(busy), 32'd1);
                checkOutput({name, ".done"}, 32'(done), 32'(k == finishK));
            end

            if (fillNow) begin
                pix++;
                if (pix == n) finishK = k + 1;
            end
            if (abortNow || rstNow || k == finishK) over = 1'b1;
            if (k > 400) begin
                checkOutput({name, ".timeout"}, 32'(k), 32'(finishK));
                over = 1'b1;
            end
        end

        checkIdle(name);
        checkIdle(name);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cfg_x0 = '0; cfg_y0 = '0; cfg_w = '0; cfg_h = '0; cfg_color = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.we", 32'(vram_we), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 19'd1234, 12'hABC, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("resetBus.we", 32'(vram_we), 32'd1);
        checkOutput("resetBus.addr", 32'(vram_addr), 32'd1234);
        checkIdle("postReset");

        runFill("basic", 10, 5, 3, 2, 12'hF00, 0, -1, -1, 1'b0);
        runFill("busPreempt", 10, 5, 3, 2, 12'hF00, 1, -1, -1, 1'b0);
        runFill("clipCorner", 638, 479, 10, 10, 12'h0F0, 0, -1, -1, 1'b0);
        runFill("zeroWidth", 10, 5, 0, 2, 12'h123, 0, -1, -1, 1'b0);
        runFill("offRight", 700, 5, 3, 2, 12'h321, 0, -1, -1, 1'b0);
        runFill("offBottom", 5, 480, 3, 2, 12'h321, 0, -1, -1, 1'b0);
        runFill("abort4x4", 20, 30, 4, 4, 12'h0AA, 0, 3, -1, 1'b1);
        runFill("abortSetup", 20, 30, 4, 4, 12'h0AA, 0, -2, -1, 1'b0);
        runFill("startSpam", 100, 200, 3, 3, 12'h555, 2, -1, -1, 1'b1);
        runFill("rstMid", 50, 60, 4, 3, 12'hBEE, 0, -1, 5, 1'b0);
        runFill("afterRst", 50, 60, 4, 3, 12'hBEE, 0, -1, -1, 1'b0);

        @(posedge clk);
        #1;
        cfg_x0 = 10'd1; cfg_y0 = 9'd1; cfg_w = 10'd2; cfg_h = 9'd2; cfg_color = 12'hFFF;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("rstVsStart.busyNow", 32'(busy), 32'd0);
        checkIdle("rstVsStart");

        for (int t = 0; t < 30; t++) begin
            runFill("random", $urandom_range(0, 700), $urandom_range(0, 490), $urandom_range(0, 6),
                    $urandom_range(0, 5), PIX_W'($urandom), 2,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : -1, -1, 1'(($urandom) & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
